// File: rtl/se_arbiter.sv
// se_arbiter: two-requester, non-preemptive owner arbiter for a shared
// security engine (SE). Each ownership release is followed by a scrub window
// in which the SE is held in reset, so no state leaks between requesters.
// Optional build macro: SE_ARB_TIMEOUT_EN adds a grant-age watchdog that
// revokes a grant after TIMEOUT_CYCLES cycles.
module se_arbiter #(
   parameter int unsigned SCRUB_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0,
   input  logic        i_req1,
   input  logic [63:0] i_control0,
   input  logic [63:0] i_control1,
   input  logic [63:0] i_add0,
   input  logic [63:0] i_add1,
   input  logic [63:0] i_data_in0,
   input  logic [63:0] i_data_in1,
   output logic        o_gnt0,
   output logic        o_gnt1,
   output logic [63:0] o_data_out0,
   output logic [63:0] o_data_out1,
   output logic        o_end_op0,
   output logic        o_end_op1,
   output logic        o_se_rst,
   output logic [63:0] o_se_control,
   output logic [63:0] o_se_add,
   output logic [63:0] o_se_data_in,
   input  logic [63:0] i_se_data_out,
   input  logic        i_se_end_op,
   output logic        o_timeout
);

   if (SCRUB_CYCLES < 1 || SCRUB_CYCLES > 255) begin : g_bad_scrub
      $error("se_arbiter: SCRUB_CYCLES must be in 1..255");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("se_arbiter: TIMEOUT_CYCLES must be in 1..65535");
   end

   localparam logic [7:0] SCRUB_LOAD = 8'(SCRUB_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT0  = 2'd1,
      ST_GNT1  = 2'd2,
      ST_SCRUB = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic       r_last_owner;
   logic       w_next_last_owner;
   logic [7:0] r_scrub_cnt;
   logic [7:0] w_next_scrub_cnt;
   logic       r_live;
   logic       w_req0_ok;
   logic       w_req1_ok;
   logic       w_timeout;

`ifdef SE_ARB_TIMEOUT_EN
   localparam logic [15:0] AGE_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_age;
   logic        r_block0;
   logic        r_block1;

   // Revoke fires in the last permitted grant cycle, only if the owner still holds its request
   assign w_timeout = r_age == AGE_LAST &&
                      ((r_state == ST_GNT0 && i_req0) || (r_state == ST_GNT1 && i_req1));
   assign w_req0_ok = i_req0 && !r_block0;
   assign w_req1_ok = i_req1 && !r_block1;

   // Grant-age counter: zero outside a grant, counts cycles while the grant holds
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_age <= '0;
      end else if ((r_state == ST_GNT0 || r_state == ST_GNT1) && w_next_state == r_state) begin
         r_age <= r_age + 16'd1;
      end else begin
         r_age <= '0;
      end
   end

   // Revoked requester stays blocked until IDLE samples its request low
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_block0 <= 1'b0;
         r_block1 <= 1'b0;
      end else begin
         if (w_timeout && r_state == ST_GNT0) begin
            r_block0 <= 1'b1;
         end else if (r_state == ST_IDLE && !i_req0) begin
            r_block0 <= 1'b0;
         end
         if (w_timeout && r_state == ST_GNT1) begin
            r_block1 <= 1'b1;
         end else if (r_state == ST_IDLE && !i_req1) begin
            r_block1 <= 1'b0;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_req0_ok = i_req0;
   assign w_req1_ok = i_req1;
`endif

   assign o_timeout = w_timeout;

   // SE reset is released one cycle after arbiter reset and re-asserted during scrub
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // State, last-owner and scrub counter registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_last_owner <= 1'b1;
         r_scrub_cnt  <= '0;
      end else begin
         r_state      <= w_next_state;
         r_last_owner <= w_next_last_owner;
         r_scrub_cnt  <= w_next_scrub_cnt;
      end
   end

   // Next-state: arbitrate in IDLE, hold grants until release or revoke, count down scrub
   always_comb begin
      w_next_state      = r_state;
      w_next_last_owner = r_last_owner;
      w_next_scrub_cnt  = r_scrub_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_req0_ok && w_req1_ok) begin
               w_next_state = r_last_owner ? ST_GNT0 : ST_GNT1;
            end else if (w_req0_ok) begin
               w_next_state = ST_GNT0;
            end else if (w_req1_ok) begin
               w_next_state = ST_GNT1;
            end
         end
         ST_GNT0: begin
            if (!i_req0 || w_timeout) begin
               w_next_state      = ST_SCRUB;
               w_next_last_owner = 1'b0;
               w_next_scrub_cnt  = SCRUB_LOAD;
            end
         end
         ST_GNT1: begin
            if (!i_req1 || w_timeout) begin
               w_next_state      = ST_SCRUB;
               w_next_last_owner = 1'b1;
               w_next_scrub_cnt  = SCRUB_LOAD;
            end
         end
         ST_SCRUB: begin
            w_next_scrub_cnt = r_scrub_cnt - 8'd1;
            if (r_scrub_cnt <= 8'd1) begin
               w_next_state     = ST_IDLE;
               w_next_scrub_cnt = '0;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign o_se_rst = r_live && (r_state != ST_SCRUB);

   // Output steering: owner sees the SE, everyone else sees zeros
   always_comb begin
      o_gnt0       = 1'b0;
      o_gnt1       = 1'b0;
      o_data_out0  = '0;
      o_data_out1  = '0;
      o_end_op0    = 1'b0;
      o_end_op1    = 1'b0;
      o_se_control = '0;
      o_se_add     = '0;
      o_se_data_in = '0;
      case (r_state)
         ST_GNT0: begin
            o_gnt0       = 1'b1;
            o_data_out0  = i_se_data_out;
            o_end_op0    = i_se_end_op;
            o_se_control = i_control0;
            o_se_add     = i_add0;
            o_se_data_in = i_data_in0;
         end
         ST_GNT1: begin
            o_gnt1       = 1'b1;
            o_data_out1  = i_se_data_out;
            o_end_op1    = i_se_end_op;
            o_se_control = i_control1;
            o_se_add     = i_add1;
            o_se_data_in = i_data_in1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_se_arbiter.sv
// tb_se_arbiter: directed stimulus against a cycle-level ownership model,
// plus literal expectations for reset, first grant, scrub length and reset.
module tb_se_arbiter;

   localparam int unsigned S = 4;
`ifdef SE_ARB_TIMEOUT_EN
   localparam int unsigned T   = 10;
   localparam bit          TEN = 1'b1;
`else
   localparam int unsigned T   = 65535;
   localparam bit          TEN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [63:0] ctl0 = '0, ctl1 = '0, add0 = '0, add1 = '0, din0 = '0, din1 = '0;
   logic [63:0] se_dout = '0;
   logic        se_end = 1'b0;
   logic        gnt0, gnt1, end0, end1, se_rst, tmo;
   logic [63:0] dout0, dout1, se_ctl, se_add, se_din;

   se_arbiter #(.SCRUB_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0(req0), .i_req1(req1),
      .i_control0(ctl0), .i_control1(ctl1),
      .i_add0(add0), .i_add1(add1),
      .i_data_in0(din0), .i_data_in1(din1),
      .o_gnt0(gnt0), .o_gnt1(gnt1),
      .o_data_out0(dout0), .o_data_out1(dout1),
      .o_end_op0(end0), .o_end_op1(end1),
      .o_se_rst(se_rst), .o_se_control(se_ctl), .o_se_add(se_add), .o_se_data_in(se_din),
      .i_se_data_out(se_dout), .i_se_end_op(se_end),
      .o_timeout(tmo)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Ownership model: who owns the SE this cycle, scrub cycles left, fairness and revoke memory
   int m_owner = -1;
   int m_scrub = 0;
   bit m_last  = 1'b1;
   int m_age   = 0;
   bit m_blk0  = 1'b0;
   bit m_blk1  = 1'b0;
   bit m_live  = 1'b0;

   function automatic bit owner_req();
      return (m_owner == 0) ? req0 : (m_owner == 1) ? req1 : 1'b0;
   endfunction

   function automatic bit m_tmo();
      return TEN && m_owner >= 0 && owner_req() && m_age == int'(T);
   endfunction

   always @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         m_owner = -1; m_scrub = 0; m_last = 1'b1; m_age = 0;
         m_blk0 = 1'b0; m_blk1 = 1'b0; m_live = 1'b0;
      end else begin
         bit e0, e1;
         if (m_owner >= 0) begin
            if (!owner_req() || m_tmo()) begin
               if (m_tmo()) begin
                  if (m_owner == 0) m_blk0 = 1'b1; else m_blk1 = 1'b1;
               end
               m_last  = (m_owner == 1);
               m_owner = -1;
               m_scrub = S;
            end else begin
               m_age++;
            end
         end else if (m_scrub > 0) begin
            m_scrub--;
         end else begin
            if (!req0) m_blk0 = 1'b0;
            if (!req1) m_blk1 = 1'b0;
            e0 = req0 && !m_blk0;
            e1 = req1 && !m_blk1;
            if (e0 && e1)  m_owner = m_last ? 0 : 1;
            else if (e0)   m_owner = 0;
            else if (e1)   m_owner = 1;
            if (m_owner >= 0) m_age = 1;
         end
         m_live = 1'b1;
      end
   end

   // Per-cycle comparison of every output against the model
   bit cmp_en = 1'b0;
   always @(negedge i_clk) begin
      if (cmp_en) begin
         chk("m_gnt0", 64'(gnt0), 64'(m_owner == 0));
         chk("m_gnt1", 64'(gnt1), 64'(m_owner == 1));
         chk("m_se_rst", 64'(se_rst), 64'(m_live && m_scrub == 0 && m_owner < 0 || m_live && m_owner >= 0));
         chk("m_se_control", se_ctl, (m_owner == 0) ? ctl0 : (m_owner == 1) ? ctl1 : 64'h0);
         chk("m_se_add", se_add, (m_owner == 0) ? add0 : (m_owner == 1) ? add1 : 64'h0);
         chk("m_se_data_in", se_din, (m_owner == 0) ? din0 : (m_owner == 1) ? din1 : 64'h0);
         chk("m_data_out0", dout0, (m_owner == 0) ? se_dout : 64'h0);
         chk("m_data_out1", dout1, (m_owner == 1) ? se_dout : 64'h0);
         chk("m_end_op0", 64'(end0), 64'(m_owner == 0 && se_end));
         chk("m_end_op1", 64'(end1), 64'(m_owner == 1 && se_end));
         chk("m_timeout", 64'(tmo), 64'(m_tmo()));
         chk("m_mutex", 64'(gnt0 && gnt1), 64'h0);
      end
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge i_clk);
   endtask

   typedef struct {
      logic r0;
      logic r1;
      int   hold;
   } vec_t;

   vec_t vecs[10] = '{
      '{1'b0, 1'b1, 3},  '{1'b1, 1'b1, 10}, '{1'b1, 1'b0, 8},  '{1'b0, 1'b0, 8},
      '{1'b1, 1'b1, 12}, '{1'b0, 1'b1, 10}, '{1'b1, 1'b1, 12}, '{1'b0, 1'b0, 10},
      '{1'b1, 1'b1, 20}, '{1'b0, 1'b0, 6}
   };

   initial begin
      int i;
      int lows;
      ctl0 = 64'h0000_0030_0000_0001; ctl1 = 64'h0000_0040_0000_0002;
      add0 = 64'h0000_0000_0000_0100; add1 = 64'h0000_0000_0000_0200;
      din0 = 64'h0000_0000_0000_A0A0; din1 = 64'h0000_0000_0000_B1B1;
      se_dout = 64'h0000_0000_0000_1234;
      cmp_en = 1'b1;

      // Reset state
      repeat (2) @(posedge i_clk);
      at_neg();
      chk("rst_gnt0", 64'(gnt0), 64'h0);
      chk("rst_gnt1", 64'(gnt1), 64'h0);
      chk("rst_se_rst", 64'(se_rst), 64'h0);
      chk("rst_timeout", 64'(tmo), 64'h0);
      chk("rst_se_control", se_ctl, 64'h0);
      chk("rst_data_out0", dout0, 64'h0);

      // Single requester grant
      cyc(); i_rst = 1'b1;
      cyc(); req0 = 1'b1;
      cyc(); at_neg();
      chk("g0_gnt0", 64'(gnt0), 64'h1);
      chk("g0_se_rst", 64'(se_rst), 64'h1);
      chk("g0_se_control", se_ctl, 64'h0000_0030_0000_0001);
      chk("g0_data_out0", dout0, 64'h0000_0000_0000_1234);
      cyc(); req0 = 1'b0;
      repeat (S + 3) cyc();

      // Contention from reset, then scrub, then the other requester
      i_rst = 1'b0;
      cyc(); i_rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
      cyc(); at_neg();
      chk("c_gnt0", 64'(gnt0), 64'h1);
      chk("c_gnt1", 64'(gnt1), 64'h0);
      repeat (2) cyc();
      req0 = 1'b0;
      lows = 0;
      for (i = 1; i <= 20; i++) begin
         cyc(); at_neg();
         if (gnt1) break;
         if (!se_rst) lows++;
      end
      chk("c_scrub_low_cycles", 64'(lows), 64'd4);
      chk("c_release_to_grant", 64'(i), 64'(S + 2));

      // Owner read path while the other side waits
      cyc(); req0 = 1'b1; se_dout = 64'hDEAD_BEEF_0000_0001; se_end = 1'b1;
      at_neg();
      chk("rd_data_out1", dout1, 64'hDEAD_BEEF_0000_0001);
      chk("rd_data_out0", dout0, 64'h0);
      chk("rd_end_op0", 64'(end0), 64'h0);
      chk("rd_end_op1", 64'(end1), 64'h1);
      repeat (5) cyc();
      at_neg();
      chk("np_gnt1_held", 64'(gnt1), 64'h1);

      // Reset in the middle of a grant
      @(posedge i_clk); #3 i_rst = 1'b0;
      #1;
      chk("mr_gnt1", 64'(gnt1), 64'h0);
      chk("mr_se_rst", 64'(se_rst), 64'h0);
      chk("mr_data_out1", dout1, 64'h0);
      req0 = 1'b0;
      @(posedge i_clk); #1 i_rst = 1'b1;
      cyc(); at_neg();
      chk("mr_regrant1", 64'(gnt1), 64'h1);
      se_end = 1'b0;

      // Directed request patterns, checked by the model every cycle
      foreach (vecs[k]) begin
         cyc(); req0 = vecs[k].r0; req1 = vecs[k].r1;
         for (int c = 1; c < vecs[k].hold; c++) begin
            cyc(); se_dout = se_dout + 64'h0101; se_end = ~se_end;
         end
      end

`ifdef SE_ARB_TIMEOUT_EN
      // Watchdog revoke with the other requester pending
      cyc(); i_rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      cyc(); i_rst = 1'b1;
      begin
         int g0_cycles;
         int tmo_at;
         g0_cycles = 0; tmo_at = 0;
         for (i = 1; i <= 40; i++) begin
            cyc(); at_neg();
            if (gnt1) break;
            if (gnt0) g0_cycles++;
            if (tmo) tmo_at = g0_cycles;
         end
         chk("to_grant_len", 64'(g0_cycles), 64'd10);
         chk("to_pulse_cycle", 64'(tmo_at), 64'd10);
         chk("to_then_gnt1", 64'(gnt1), 64'h1);
      end
      // r1 releases while r0 still holds: r0 stays blocked until it drops
      cyc(); req1 = 1'b0;
      repeat (S + 4) cyc();
      at_neg();
      chk("to_blocked", 64'(gnt0), 64'h0);
      cyc(); req0 = 1'b0;
      cyc(); req0 = 1'b1;
      repeat (2) cyc();
      at_neg();
      chk("to_unblocked", 64'(gnt0), 64'h1);
`endif

      cyc(); req0 = 1'b0; req1 = 1'b0;
      repeat (S + 3) cyc();
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/se_arbiter.md
SE_ARBITER -- requirements
Module: se_arbiter

Interface
REQ-001 SHALL have parameter SCRUB_CYCLES, default 4, cycles SE held in reset after each ownership release (range 1-255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum grant length in cycles when the watchdog is compiled in (range 1-65535).
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_req0 / i_req1  input  1  requester n wants, and holds, ownership of the SE.
REQ-006 SHALL have ports i_control0 / i_control1  input  64  requester n control word {address_module[63:32], control_module[31:0]}.
REQ-007 SHALL have ports i_add0 / i_add1  input  64  requester n register address.
REQ-008 SHALL have ports i_data_in0 / i_data_in1  input  64  requester n write data.
REQ-009 SHALL have ports o_gnt0 / o_gnt1  output  1  requester n currently owns the SE.
REQ-010 SHALL have ports o_data_out0 / o_data_out1  output  64  SE read data; valid for owner only.
REQ-011 SHALL have ports o_end_op0 / o_end_op1  output  1  SE end-of-operation; valid for owner only.
REQ-012 SHALL have ports o_se_rst  output  1  active-low reset to SE; o_se_control / o_se_add / o_se_data_in  output  64 each  muxed SE inputs.
REQ-013 SHALL have ports i_se_data_out  input  64 and i_se_end_op  input  1  SE responses; o_timeout  output  1  one-cycle watchdog revoke pulse.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1, SCRUB.
REQ-015 IDLE: SHALL move to GNT0 or GNT1 on the cycle after the request is sampled; single request wins; both requests -> requester not served last (last_owner flag, reset 1, so r0 wins first contention).
REQ-016 GNTn: o_gntn=1, o_se_rst=1, o_se_control/add/data_in = requester n inputs combinationally; o_data_outn = i_se_data_out, o_end_opn = i_se_end_op.
REQ-017 Non-owner outputs SHALL be o_gnt=0, o_data_out=64'h0, o_end_op=0 in every state.
REQ-018 In IDLE and SCRUB, o_se_control SHALL be 64'h0 (no module selected), o_se_add=0, o_se_data_in=0.
REQ-019 GNTn SHALL hold while i_reqn=1; i_reqn=0 -> SCRUB next cycle, last_owner<=n; o_gntn drops same edge.
REQ-020 Grant SHALL be non-preemptive: other requester's request never shortens the current grant.
REQ-021 SCRUB: o_se_rst=0 for exactly SCRUB_CYCLES cycles via down-counter, then IDLE; requests during SCRUB are only sampled in IDLE.
REQ-022 Minimum release-to-next-grant latency SHALL be SCRUB_CYCLES+2 cycles.
REQ-023 SHALL never assert o_gnt0 and o_gnt1 simultaneously.

Reset
REQ-024 i_rst=0 SHALL asynchronously force IDLE, last_owner=1, counters 0, o_gnt0=o_gnt1=0, o_se_rst=0, o_timeout=0, all data outputs 0.
REQ-025 o_se_rst SHALL stay 0 while i_rst=0 and rise only from IDLE after release; reset mid-grant drops the grant immediately with no SCRUB.

Configuration
REQ-026 Macro SE_ARB_TIMEOUT_EN, when defined, SHALL add a 16-bit grant-age counter cleared on grant entry; reaching TIMEOUT_CYCLES in GNTn forces SCRUB, pulses o_timeout one cycle, last_owner<=n; revoked requester is not re-granted until its i_reqn has been 0 for one IDLE-sampled cycle.
REQ-027 Without SE_ARB_TIMEOUT_EN, no counter SHALL exist, o_timeout SHALL be tied 0, grants are unbounded.

Verification
REQ-028 Reset, then i_req0=1 -> o_gnt0=1 two cycles later, o_se_rst=1, o_se_control = i_control0 (e.g. 64'h0000_0030_0000_0001).
REQ-029 i_req0 and i_req1 asserted same cycle from reset -> GNT0; r0 releases -> o_se_rst=0 for 4 cycles -> GNT1.
REQ-030 r1 owns, r0 requesting; i_se_data_out=64'hDEAD_BEEF_0000_0001 -> o_data_out1 matches, o_data_out0=0, o_end_op0=0.
REQ-031 Assert i_rst=0 mid-GNT1 -> same-cycle o_gnt1=0, o_se_rst=0; after release, i_req1 granted (last_owner=1 from reset gives r1 no priority loss when alone).
REQ-032 SE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, r0 holds -> o_timeout pulses at grant cycle 10, SCRUB entered, r1 (pending) granted next.
